l2_request_arbiter: RTL and testbench
=====================================

// Module: l2_request_arbiter
// PURPOSE
//  Front-end scheduler for the L2 cache command port. Arbitrates L1 data, L1 instruction,
//  snoop and maintenance (clear/print) requesters onto the single command/address interface
//  of L2Cache, one operation outstanding at a time. Filters illegal command codes per source.
// PARAMETERS
//  commandSize      8   width of command field
//  instructionSize  32  address width
//  STARVE_LIMIT     4   consecutive snoop wins over a pending L1 request before L1 is forced
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    reset, asynchronous, active-low
//  l1d_valid/l1d_ready  in/out 1  L1 data request handshake; l1d_command in cmdSz, l1d_address in addrSz
//  l1i_valid/l1i_ready  in/out 1  L1 instr handshake; l1i_address in addrSz (command implied = 2)
//  snp_valid/snp_ready  in/out 1  snoop handshake; snp_command in cmdSz, snp_address in addrSz
//  mnt_valid/mnt_ready  in/out 1  maintenance handshake; mnt_command in cmdSz (no address)
//  l2_valid       out  1    command presented to cache
//  l2_ready       in   1    cache accepts command this cycle
//  l2_command     out  cmdSz  command to cache; l2_address out addrSz (0 for maintenance)
//  l2_done        in   1    cache finished current operation (1-cycle pulse)
//  grant_src      out  2    0=L1D 1=L1I 2=SNP 3=MNT; owner of in-flight op
//  busy           out  1    operation in flight (state != IDLE)
//  illegal        out  1    1-cycle pulse: an illegal command was accepted and dropped
// BEHAVIOUR
//  - Reset: state IDLE; all *_ready, l2_valid, l2_command, l2_address, grant_src, busy, illegal = 0;
//    rr pointer = L1D; starve_cnt = 0. Reset mid-op clears l2_valid immediately, op abandoned.
//  - FSM: IDLE -> ISSUE on accept of a legal request; ISSUE -> WAIT on l2_ready;
//    ISSUE -> IDLE if l2_ready && l2_done same cycle; WAIT -> IDLE on l2_done. l2_done ignored in IDLE.
//  - Ready: combinational, X_ready = (state==IDLE) && (winner==X); at most one ready high.
//  - Accept at cycle N (valid&&ready): cmd/addr registered; l2_valid=1 from N+1, held with stable
//    l2_command/l2_address until l2_ready. Earliest re-accept: cycle after return to IDLE.
//  - Priority: MNT > SNP > {L1D,L1I}; L1 pair round-robin, rr toggles after each legal L1 grant.
//  - Starvation: starve_cnt++ (saturating at STARVE_LIMIT) when SNP wins while any L1 valid;
//    when starve_cnt==STARVE_LIMIT the L1 pair outranks SNP (not MNT); cleared on L1 grant.
//  - Legal codes: L1D {0,1}; SNP {3,4,5,6}; MNT {8,9}; L1I always 2. Illegal: accepted (ready
//    pulses), not issued, illegal=1 at N+1, FSM stays IDLE, rr and starve_cnt unchanged.
//  - Completion of MNT cmd 8 (clear): rr -> L1D, starve_cnt -> 0 in the IDLE-return cycle.
//  - Requesters must hold valid/command/address until ready; arbiter does not re-check a dropped
//    valid (no state change if valid deasserts before grant).
// STRUCTURE
//  - l2_cache_pkg: CMD_* localparams (0,1,2,3,4,5,6,8,9), SRC_* encodings, FSM state encoding.
//  - Sub-module l2_rr_arbiter: combinational winner select from valids, rr pointer, starve flag.
//  - Top: FSM, request registers, rr/starve counters, legality check.
// TESTING
//  1 Reset with all valids high -> all readies 0; release -> mnt_ready first, l2_valid next cycle.
//  2 l1d(cmd1,addr 0x0000_1000) & l1i(0x2000) both held, l2_ready=1, done 2 cycles later
//    -> grants alternate L1D,L1I,L1D; grant_src follows.
//  3 snp(cmd4) always valid, l1d pending -> 4 snoop grants then L1D granted; starve_cnt cleared.
//  4 l1d_command=7 -> l1d_ready pulse, illegal=1 next cycle, l2_valid stays 0, rr unchanged.
//  5 l2_ready held 0 for 5 cycles -> l2_command/l2_address stable, no other ready asserted.
//  6 rst_n low during WAIT -> l2_valid, busy 0 asynchronously; after release normal arbitration.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared encodings for the L2 request arbiter: command codes, requester ids and FSM states.
package l2_cache_pkg;

  localparam int unsigned CMD_L1D_READ  = 0;
  localparam int unsigned CMD_L1D_WRITE = 1;
  localparam int unsigned CMD_L1I_FETCH = 2;
  localparam int unsigned CMD_SNP_INV   = 3;
  localparam int unsigned CMD_SNP_CLEAN = 4;
  localparam int unsigned CMD_SNP_SHARE = 5;
  localparam int unsigned CMD_SNP_FLUSH = 6;
  localparam int unsigned CMD_MNT_CLEAR = 8;
  localparam int unsigned CMD_MNT_PRINT = 9;

  localparam logic [1:0] SRC_L1D = 2'd0;
  localparam logic [1:0] SRC_L1I = 2'd1;
  localparam logic [1:0] SRC_SNP = 2'd2;
  localparam logic [1:0] SRC_MNT = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

endpackage

// File: rtl/l2_request_arbiter_rr.sv
// Combinational winner select: MNT > SNP > L1 pair, with a starvation override lifting
// the L1 pair above SNP. The L1 pair is resolved by the round-robin pointer.
module l2_rr_arbiter
  import l2_cache_pkg::*;
(
  input  logic       l1d_valid,
  input  logic       l1i_valid,
  input  logic       snp_valid,
  input  logic       mnt_valid,
  input  logic       rr_ptr,      // 0 prefers L1D, 1 prefers L1I
  input  logic       starve,
  output logic       any_valid,
  output logic       l1_pending,
  output logic [1:0] winner
);

  logic [1:0] l1_winner;

  always_comb begin
    any_valid  = l1d_valid | l1i_valid | snp_valid | mnt_valid;
    l1_pending = l1d_valid | l1i_valid;

    if (l1d_valid && l1i_valid) begin
      l1_winner = rr_ptr ? SRC_L1I : SRC_L1D;
    end else begin
      l1_winner = l1i_valid ? SRC_L1I : SRC_L1D;
    end

    winner = SRC_L1D;
    if (mnt_valid) begin
      winner = SRC_MNT;
    end else if (starve && l1_pending) begin
      winner = l1_winner;
    end else if (snp_valid) begin
      winner = SRC_SNP;
    end else if (l1_pending) begin
      winner = l1_winner;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// L2 command-port scheduler: arbitrates L1D/L1I/snoop/maintenance requesters onto a single
// cache command interface with one operation in flight, dropping illegal command codes.
module l2_request_arbiter
  import l2_cache_pkg::*;
#(
  parameter int unsigned commandSize     = 8,
  parameter int unsigned instructionSize = 32,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       l1d_valid,
  output logic                       l1d_ready,
  input  logic [commandSize-1:0]     l1d_command,
  input  logic [instructionSize-1:0] l1d_address,
  input  logic                       l1i_valid,
  output logic                       l1i_ready,
  input  logic [instructionSize-1:0] l1i_address,
  input  logic                       snp_valid,
  output logic                       snp_ready,
  input  logic [commandSize-1:0]     snp_command,
  input  logic [instructionSize-1:0] snp_address,
  input  logic                       mnt_valid,
  output logic                       mnt_ready,
  input  logic [commandSize-1:0]     mnt_command,
  output logic                       l2_valid,
  input  logic                       l2_ready,
  output logic [commandSize-1:0]     l2_command,
  output logic [instructionSize-1:0] l2_address,
  input  logic                       l2_done,
  output logic [1:0]                 grant_src,
  output logic                       busy,
  output logic                       illegal
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  state_e                     state_q, state_d;
  logic [commandSize-1:0]     cmd_q, cmd_d;
  logic [instructionSize-1:0] addr_q, addr_d;
  logic [1:0]                 src_q, src_d;
  logic                       rr_q, rr_d;
  logic [StarveW-1:0]         starve_q, starve_d;
  logic                       illegal_q, illegal_d;

  logic                       any_valid, l1_pending, starve_hit, accept, cmd_legal, op_done;
  logic [1:0]                 winner;
  logic [commandSize-1:0]     sel_cmd;
  logic [instructionSize-1:0] sel_addr;

  assign starve_hit = (starve_q == StarveW'(STARVE_LIMIT));

  l2_rr_arbiter u_rr_arbiter (
    .l1d_valid  (l1d_valid),
    .l1i_valid  (l1i_valid),
    .snp_valid  (snp_valid),
    .mnt_valid  (mnt_valid),
    .rr_ptr     (rr_q),
    .starve     (starve_hit),
    .any_valid  (any_valid),
    .l1_pending (l1_pending),
    .winner     (winner)
  );

  // Readies are also held low while reset is asserted, not just from the state register.
  assign accept    = rst_n && (state_q == StIdle) && any_valid;
  assign l1d_ready = accept && (winner == SRC_L1D);
  assign l1i_ready = accept && (winner == SRC_L1I);
  assign snp_ready = accept && (winner == SRC_SNP);
  assign mnt_ready = accept && (winner == SRC_MNT);

  always_comb begin
    sel_cmd   = '0;
    sel_addr  = '0;
    cmd_legal = 1'b0;
    case (winner)
      SRC_L1D: begin
        sel_cmd   = l1d_command;
        sel_addr  = l1d_address;
        cmd_legal = (l1d_command == commandSize'(CMD_L1D_READ)) ||
                    (l1d_command == commandSize'(CMD_L1D_WRITE));
      end
      SRC_L1I: begin
        sel_cmd   = commandSize'(CMD_L1I_FETCH);
        sel_addr  = l1i_address;
        cmd_legal = 1'b1;
      end
      SRC_SNP: begin
        sel_cmd   = snp_command;
        sel_addr  = snp_address;
        cmd_legal = (snp_command >= commandSize'(CMD_SNP_INV)) &&
                    (snp_command <= commandSize'(CMD_SNP_FLUSH));
      end
      default: begin
        sel_cmd   = mnt_command;
        cmd_legal = (mnt_command == commandSize'(CMD_MNT_CLEAR)) ||
                    (mnt_command == commandSize'(CMD_MNT_PRINT));
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    src_d     = src_q;
    rr_d      = rr_q;
    starve_d  = starve_q;
    illegal_d = 1'b0;
    op_done   = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_legal) begin
            state_d = StIssue;
            cmd_d   = sel_cmd;
            addr_d  = sel_addr;
            src_d   = winner;
            if ((winner == SRC_L1D) || (winner == SRC_L1I)) begin
              rr_d     = ~rr_q;
              starve_d = '0;
            end else if ((winner == SRC_SNP) && l1_pending && !starve_hit) begin
              starve_d = starve_q + StarveW'(1);
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (l2_ready) begin
          if (l2_done) begin
            state_d = StIdle;
            op_done = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (l2_done) begin
          state_d = StIdle;
          op_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A completed clear restores arbitration fairness state to its reset values.
    if (op_done && (src_q == SRC_MNT) && (cmd_q == commandSize'(CMD_MNT_CLEAR))) begin
      rr_d     = 1'b0;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      addr_q    <= '0;
      src_q     <= SRC_L1D;
      rr_q      <= 1'b0;
      starve_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      illegal_q <= illegal_d;
    end
  end

  assign l2_valid   = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign l2_command = cmd_q;
  assign l2_address = addr_q;
  assign grant_src  = src_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Scoreboarded bench for l2_request_arbiter: a cache model pops expected grants on each
// l2_valid/l2_ready handshake while per-scenario tasks drive requesters and check inline.
module tb_l2_request_arbiter;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l1d_valid, l1d_ready, l1i_valid, l1i_ready;
  logic          snp_valid, snp_ready, mnt_valid, mnt_ready;
  logic [CW-1:0] l1d_command, snp_command, mnt_command, l2_command;
  logic [AW-1:0] l1d_address, l1i_address, snp_address, l2_address;
  logic          l2_valid, l2_ready, l2_done, busy, illegal;
  logic [1:0]    grant_src;

  typedef struct packed {
    logic [1:0]    src;
    logic [CW-1:0] cmd;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  always #5 clk = ~clk;

  l2_request_arbiter #(
    .commandSize     (CW),
    .instructionSize (AW),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .l1d_valid   (l1d_valid),
    .l1d_ready   (l1d_ready),
    .l1d_command (l1d_command),
    .l1d_address (l1d_address),
    .l1i_valid   (l1i_valid),
    .l1i_ready   (l1i_ready),
    .l1i_address (l1i_address),
    .snp_valid   (snp_valid),
    .snp_ready   (snp_ready),
    .snp_command (snp_command),
    .snp_address (snp_address),
    .mnt_valid   (mnt_valid),
    .mnt_ready   (mnt_ready),
    .mnt_command (mnt_command),
    .l2_valid    (l2_valid),
    .l2_ready    (l2_ready),
    .l2_command  (l2_command),
    .l2_address  (l2_address),
    .l2_done     (l2_done),
    .grant_src   (grant_src),
    .busy        (busy),
    .illegal     (illegal)
  );

  function automatic exp_t mk(input logic [1:0] src, input logic [CW-1:0] cmd,
                              input logic [AW-1:0] addr);
    exp_t e;
    e.src  = src;
    e.cmd  = cmd;
    e.addr = addr;
    return e;
  endfunction

  // Cache model: compares each accepted command against the scoreboard, pulses done 2 cycles on.
  task automatic cache_monitor();
    int   pending;
    exp_t e;
    pending = 0;
    forever begin
      @(negedge clk);
      if (l2_valid && l2_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected got src=%0d cmd=%0h addr=%0h required no grant",
                   grant_src, l2_command, l2_address);
        end else begin
          e = exp_q.pop_front();
          if ({grant_src, l2_command, l2_address} !== e) begin
            failures++;
            $display("FAIL grant_%0d got src=%0d cmd=%0h addr=%0h required src=%0d cmd=%0h addr=%0h",
                     pops, grant_src, l2_command, l2_address, e.src, e.cmd, e.addr);
          end
        end
        pops++;
        pending = 2;
      end
      @(posedge clk);
      #1;
      l2_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) l2_done = 1'b1;
      end
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #2;
      if (pops >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic drop_all();
    l1d_valid = 1'b0;
    l1i_valid = 1'b0;
    snp_valid = 1'b0;
    mnt_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int base;
    rst_n = 1'b0;
    l1d_valid = 1'b1; l1d_command = 8'd0; l1d_address = 32'h0000_1000;
    l1i_valid = 1'b1; l1i_address = 32'h0000_2000;
    snp_valid = 1'b1; snp_command = 8'd4; snp_address = 32'h0000_00a0;
    mnt_valid = 1'b1; mnt_command = 8'd8;
    repeat (3) @(negedge clk);
    checks++;
    if ({l1d_ready, l1i_ready, snp_ready, mnt_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got %b required 0000",
               {l1d_ready, l1i_ready, snp_ready, mnt_ready});
    end
    checks++;
    if ({l2_valid, busy, illegal} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status got %b required 000", {l2_valid, busy, illegal});
    end
    checks++;
    if ({grant_src, l2_command, l2_address} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got src=%0d cmd=%0h addr=%0h required all 0",
               grant_src, l2_command, l2_address);
    end
    base = pops;
    exp_q.push_back(mk(2'd3, 8'd8, 32'h0));
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    l2_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({l1d_ready, l1i_ready, snp_ready, mnt_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL release_ready got %b required 0001",
               {l1d_ready, l1i_ready, snp_ready, mnt_ready});
    end
    @(posedge clk);
    #1;
    drop_all();
    @(negedge clk);
    checks++;
    if ({l2_valid, busy} !== 2'b11) begin
      failures++;
      $display("FAIL release_issue got l2_valid,busy=%b required 11", {l2_valid, busy});
    end
    wait_pops(base + 1, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_grant_timeout got none required 1"); end
    wait_idle(20, ok);
  endtask

  task automatic test_l1_round_robin();
    bit ok;
    int base;
    base = pops;
    exp_q.push_back(mk(2'd0, 8'd1, 32'h0000_1000));
    exp_q.push_back(mk(2'd1, 8'd2, 32'h0000_2000));
    exp_q.push_back(mk(2'd0, 8'd1, 32'h0000_1000));
    @(posedge clk);
    #1;
    l1d_valid = 1'b1; l1d_command = 8'd1; l1d_address = 32'h0000_1000;
    l1i_valid = 1'b1; l1i_address = 32'h0000_2000;
    wait_pops(base + 3, 60, ok);
    drop_all();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_timeout got %0d grants required 3", pops - base);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_starvation();
    bit ok;
    int base;
    base = pops;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) exp_q.push_back(mk(2'd2, 8'd4, 32'h0000_00a0));
      exp_q.push_back(mk(2'd0, 8'd0, 32'h0000_3000));
    end
    @(posedge clk);
    #1;
    snp_valid = 1'b1; snp_command = 8'd4; snp_address = 32'h0000_00a0;
    l1d_valid = 1'b1; l1d_command = 8'd0; l1d_address = 32'h0000_3000;
    wait_pops(base + 10, 150, ok);
    drop_all();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL starve_timeout got %0d grants required 10", pops - base);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_illegal();
    bit ok;
    int base;
    base = pops;
    exp_q.push_back(mk(2'd3, 8'd8, 32'h0));
    @(posedge clk);
    #1;
    mnt_valid = 1'b1; mnt_command = 8'd8;
    wait_pops(base + 1, 20, ok);
    drop_all();
    wait_idle(20, ok);
    @(posedge clk);
    #1;
    l1d_valid = 1'b1; l1d_command = 8'd7; l1d_address = 32'h0000_4000;
    @(negedge clk);
    checks++;
    if (l1d_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal_ready got %b required 1", l1d_ready);
    end
    @(posedge clk);
    #1;
    l1d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({illegal, l2_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL illegal_pulse got illegal,l2_valid,busy=%b required 100",
               {illegal, l2_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({illegal, l2_valid} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_clear got illegal,l2_valid=%b required 00", {illegal, l2_valid});
    end
    // rr must still prefer L1D after the dropped command.
    base = pops;
    exp_q.push_back(mk(2'd0, 8'd0, 32'h0000_5000));
    exp_q.push_back(mk(2'd1, 8'd2, 32'h0000_6000));
    @(posedge clk);
    #1;
    l1d_valid = 1'b1; l1d_command = 8'd0; l1d_address = 32'h0000_5000;
    l1i_valid = 1'b1; l1i_address = 32'h0000_6000;
    wait_pops(base + 2, 40, ok);
    drop_all();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL illegal_rr_timeout got %0d grants required 2", pops - base);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_stall();
    bit ok;
    int base;
    base = pops;
    l2_ready = 1'b0;
    exp_q.push_back(mk(2'd3, 8'd9, 32'h0));
    exp_q.push_back(mk(2'd0, 8'd1, 32'h0000_7000));
    @(posedge clk);
    #1;
    mnt_valid = 1'b1; mnt_command = 8'd9;
    l1d_valid = 1'b1; l1d_command = 8'd1; l1d_address = 32'h0000_7000;
    @(negedge clk);
    checks++;
    if ({l1d_ready, mnt_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_accept got l1d,mnt ready=%b required 01", {l1d_ready, mnt_ready});
    end
    @(posedge clk);
    #1;
    mnt_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({l2_valid, l2_command, l2_address, l1d_ready, l1i_ready, snp_ready, mnt_ready}
          !== {1'b1, 8'd9, 32'h0, 4'b0000}) begin
        failures++;
        $display("FAIL stall_hold_%0d got valid=%b cmd=%0h addr=%0h rdy=%b required 1 9 0 0000",
                 c, l2_valid, l2_command, l2_address,
                 {l1d_ready, l1i_ready, snp_ready, mnt_ready});
      end
    end
    @(posedge clk);
    #1;
    l2_ready = 1'b1;
    wait_pops(base + 2, 40, ok);
    drop_all();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout got %0d grants required 2", pops - base);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int base;
    base = pops;
    exp_q.push_back(mk(2'd2, 8'd3, 32'h0000_00b0));
    @(posedge clk);
    #1;
    snp_valid = 1'b1; snp_command = 8'd3; snp_address = 32'h0000_00b0;
    wait_pops(base + 1, 20, ok);
    drop_all();
    #1;
    checks++;
    if ({busy, l2_valid, grant_src} !== {2'b10, 2'd2}) begin
      failures++;
      $display("FAIL midop_wait got busy,l2_valid,src=%b required 1010",
               {busy, l2_valid, grant_src});
    end
    l1i_valid   = 1'b1;
    l1i_address = 32'h0000_8000;
    rst_n       = 1'b0;
    #1;
    checks++;
    if ({l2_valid, busy, grant_src, l1i_ready} !== 5'b00000) begin
      failures++;
      $display("FAIL midop_async_reset got l2_valid,busy,src,l1i_ready=%b required 00000",
               {l2_valid, busy, grant_src, l1i_ready});
    end
    base = pops;
    exp_q.push_back(mk(2'd1, 8'd2, 32'h0000_8000));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_pops(base + 1, 20, ok);
    drop_all();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midop_recover_timeout got 0 grants required 1");
    end
    wait_idle(20, ok);
  endtask

  initial begin
    rst_n = 1'b0;
    drop_all();
    l1d_command = '0; l1d_address = '0; l1i_address = '0;
    snp_command = '0; snp_address = '0; mnt_command = '0;
    l2_ready = 1'b0;
    l2_done  = 1'b0;
    fork
      cache_monitor();
    join_none
    test_reset();
    test_l1_round_robin();
    test_starvation();
    test_illegal();
    test_stall();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
